// File: rtl/paam_agc_cmd_sched.sv
// AGC command scheduler towards the PAAM: queues masked per-panel commands and drives
// them onto the pins with programmable setup / valid / hold timing.
module paam_agc_cmd_sched #(
    parameter int unsigned NUM_PANELS = 4,
    parameter int unsigned CMD_W      = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned VALID_CYC  = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned TRIG_MODE  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [NUM_PANELS*CMD_W-1:0]      s_cmd,
    input  logic [NUM_PANELS-1:0]            s_mask,
    input  logic                             flush,
    input  logic                             sym_strobe,
    output logic [NUM_PANELS*CMD_W-1:0]      agc_cmd,
    output logic                             agc_cmd_valid,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             trig_miss
);

    localparam int unsigned DATA_W  = NUM_PANELS * CMD_W;
    localparam int unsigned ENTRY_W = DATA_W + NUM_PANELS;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned MAX_SV  = (SETUP_CYC > VALID_CYC) ? SETUP_CYC : VALID_CYC;
    localparam int unsigned MAX_CYC = (MAX_SV > HOLD_CYC) ? MAX_SV : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StValid, StHold} state_e;

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 launch;
    logic [ENTRY_W-1:0]   head;
    logic [DATA_W-1:0]    head_cmd;
    logic [NUM_PANELS-1:0] head_mask;
    logic [DATA_W-1:0]    merged;

    assign full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign s_ready   = !full;
    // A flushed push never enters the queue, so it does not advance the write pointer.
    assign push      = s_valid && !full && !flush;
    assign launch    = (state == StIdle) && !empty && ((TRIG_MODE == 0) || sym_strobe);
    assign head      = mem[rd_ptr];
    assign head_cmd  = head[DATA_W-1:0];
    assign head_mask = head[ENTRY_W-1:DATA_W];

    always_comb begin
        merged = agc_cmd;
        for (int p = 0; p < int'(NUM_PANELS); p++) begin
            if (head_mask[p]) begin
                merged[p*CMD_W +: CMD_W] = head_cmd[p*CMD_W +: CMD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_mask, s_cmd};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (launch) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(launch);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            cnt           <= '0;
            agc_cmd       <= '0;
            agc_cmd_valid <= 1'b0;
            busy          <= 1'b0;
            trig_miss     <= 1'b0;
        end else begin
            trig_miss <= (TRIG_MODE != 0) && sym_strobe && (state != StIdle) && !empty;
            unique case (state)
                StIdle: begin
                    if (launch) begin
                        agc_cmd <= merged;
                        state   <= StSetup;
                        cnt     <= CNT_W'(SETUP_CYC);
                        busy    <= 1'b1;
                    end
                end
                StSetup: begin
                    if (cnt == CNT_W'(1)) begin
                        state         <= StValid;
                        cnt           <= CNT_W'(VALID_CYC);
                        agc_cmd_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                StValid: begin
                    if (cnt == CNT_W'(1)) begin
                        state         <= StHold;
                        cnt           <= CNT_W'(HOLD_CYC);
                        agc_cmd_valid <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                StHold: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_paam_agc_cmd_sched.sv
// Bench for paam_agc_cmd_sched: an immediate-mode and a strobe-triggered instance share
// stimulus and are each compared every cycle against a transaction-timeline model.
module tb_paam_agc_cmd_sched;

    localparam int NP    = 4;
    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int SC    = 2;
    localparam int VC    = 4;
    localparam int HC    = 2;
    localparam int DW    = NP * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_cmd = '0;
    logic [NP-1:0] s_mask = '0;
    logic          flush = 1'b0;
    logic          sym_strobe = 1'b0;

    logic          s_ready [2];
    logic [DW-1:0] agc_cmd [2];
    logic          agc_cmd_valid [2];
    logic          busy [2];
    logic [3:0]    fifo_level [2];
    logic          trig_miss [2];

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;
    int miss_seen = 0;

    // Reference model state, one slot per instance (0 = immediate, 1 = triggered).
    logic [DW-1:0] m_qc [2][DEPTH];
    logic [NP-1:0] m_qm [2][DEPTH];
    int            m_cnt [2];
    logic [DW-1:0] m_cur [2];
    int            m_age [2];
    bit            m_active [2];
    bit            m_miss [2];

    always #5 clk = ~clk;

    paam_agc_cmd_sched #(
        .NUM_PANELS(NP), .CMD_W(CW), .FIFO_DEPTH(DEPTH),
        .SETUP_CYC(SC), .VALID_CYC(VC), .HOLD_CYC(HC), .TRIG_MODE(0)
    ) u_dut_imm (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[0]), .s_cmd(s_cmd),
        .s_mask(s_mask), .flush(flush), .sym_strobe(sym_strobe), .agc_cmd(agc_cmd[0]),
        .agc_cmd_valid(agc_cmd_valid[0]), .busy(busy[0]), .fifo_level(fifo_level[0]),
        .trig_miss(trig_miss[0])
    );

    paam_agc_cmd_sched #(
        .NUM_PANELS(NP), .CMD_W(CW), .FIFO_DEPTH(DEPTH),
        .SETUP_CYC(SC), .VALID_CYC(VC), .HOLD_CYC(HC), .TRIG_MODE(1)
    ) u_dut_trg (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready[1]), .s_cmd(s_cmd),
        .s_mask(s_mask), .flush(flush), .sym_strobe(sym_strobe), .agc_cmd(agc_cmd[1]),
        .agc_cmd_valid(agc_cmd_valid[1]), .busy(busy[1]), .fifo_level(fifo_level[1]),
        .trig_miss(trig_miss[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30) begin
                $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string pfx;
            bit    exp_valid;
            pfx = (i == 0) ? "imm" : "trg";
            exp_valid = m_active[i] && (m_age[i] > SC) && (m_age[i] <= SC + VC);
            check_eq({pfx, ".s_ready"}, 32'(s_ready[i]), 32'(m_cnt[i] < DEPTH));
            check_eq({pfx, ".agc_cmd"}, 32'(agc_cmd[i]), 32'(m_cur[i]));
            check_eq({pfx, ".valid"}, 32'(agc_cmd_valid[i]), 32'(exp_valid));
            check_eq({pfx, ".busy"}, 32'(busy[i]), 32'(m_active[i]));
            check_eq({pfx, ".level"}, 32'(fifo_level[i]), 32'(m_cnt[i]));
            check_eq({pfx, ".trig_miss"}, 32'(trig_miss[i]), 32'(m_miss[i]));
        end
    endtask

    // Advance the model over one clock edge using the inputs currently driven.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit ready;
            bit launch;
            bit miss;
            bit push;
            ready  = m_cnt[i] < DEPTH;
            launch = !m_active[i] && (m_cnt[i] > 0) && ((i == 0) || sym_strobe);
            miss   = (i == 1) && sym_strobe && m_active[i] && (m_cnt[i] > 0);
            push   = s_valid && ready;
            if (rst) begin
                m_cnt[i]    = 0;
                m_cur[i]    = '0;
                m_active[i] = 1'b0;
                m_age[i]    = 0;
                m_miss[i]   = 1'b0;
            end else begin
                if (launch) begin
                    for (int p = 0; p < NP; p++) begin
                        if (m_qm[i][0][p]) m_cur[i][p*CW +: CW] = m_qc[i][0][p*CW +: CW];
                    end
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        m_qc[i][k] = m_qc[i][k+1];
                        m_qm[i][k] = m_qm[i][k+1];
                    end
                    m_cnt[i]--;
                    m_active[i] = 1'b1;
                    m_age[i]    = 1;
                end else if (m_active[i]) begin
                    m_age[i]++;
                    if (m_age[i] > SC + VC + HC) m_active[i] = 1'b0;
                end
                if (flush) begin
                    m_cnt[i] = 0;
                end else if (push) begin
                    m_qc[i][m_cnt[i]] = s_cmd;
                    m_qm[i][m_cnt[i]] = s_mask;
                    m_cnt[i]++;
                end
                m_miss[i] = miss;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input logic [DW-1:0] c,
                         input logic [NP-1:0] m, input bit f, input bit st);
        @(negedge clk);
        if (checking) check_all();
        if (trig_miss[1]) miss_seen++;
        rst = r;
        s_valid = v;
        s_cmd = c;
        s_mask = m;
        flush = f;
        sym_strobe = st;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        checking = 1'b1;

        // Single push, immediate mode latency.
        cycle(1'b0, 1'b1, 16'h4321, 4'hF, 1'b0, 1'b0);
        idle(2);
        check_eq("dir.cmd_t2", 32'(agc_cmd[0]), 32'h4321);
        idle(2);
        check_eq("dir.valid_t4", 32'(agc_cmd_valid[0]), 32'd1);
        idle(3);
        check_eq("dir.valid_t7", 32'(agc_cmd_valid[0]), 32'd1);
        idle(1);
        check_eq("dir.valid_t8", 32'(agc_cmd_valid[0]), 32'd0);
        check_eq("dir.busy_t8", 32'(busy[0]), 32'd1);
        idle(2);
        check_eq("dir.busy_t10", 32'(busy[0]), 32'd0);

        // Masked update of panels 0 and 2.
        cycle(1'b0, 1'b1, 16'hAAAA, 4'b0101, 1'b0, 1'b0);
        idle(2);
        check_eq("dir.mask", 32'(agc_cmd[0]), 32'h4A2A);
        idle(10);

        // Back-to-back pushes fill the queue.
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b1, DW'($urandom), 4'hF, 1'b0, 1'b0);
        idle(110);
        check_eq("dir.drained", 32'(fifo_level[0]), 32'd0);

        // Triggered mode: two commands, strobe every fifth cycle.
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, DW'($urandom), 4'hF, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, DW'($urandom), 4'hF, 1'b0, 1'b0);
        miss_seen = 0;
        for (int k = 0; k < 40; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, (k % 5) == 4);
        check_eq("trg.miss_seen", 32'(miss_seen > 0), 32'd1);
        check_eq("trg.level", 32'(fifo_level[1]), 32'd0);

        // Flush while a valid pulse is in flight.
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, DW'($urandom), 4'hF, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(12);
        check_eq("flush.level", 32'(fifo_level[0]), 32'd0);
        check_eq("flush.busy", 32'(busy[0]), 32'd0);

        // Reset in the middle of a valid phase.
        cycle(1'b0, 1'b1, 16'h5A5A, 4'hF, 1'b0, 1'b0);
        idle(4);
        check_eq("rst.pre_valid", 32'(agc_cmd_valid[0]), 32'd1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1);
        check_eq("rst.cmd", 32'(agc_cmd[0]), 32'd0);
        check_eq("rst.valid", 32'(agc_cmd_valid[0]), 32'd0);
        check_eq("rst.level", 32'(fifo_level[0]), 32'd0);
        check_eq("rst.ready", 32'(s_ready[0]), 32'd1);

        // Randomised traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 400) == 0, $urandom_range(1, 0) == 1, DW'($urandom),
                  NP'($urandom), ($urandom % 50) == 0, ($urandom % 5) == 0);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
